// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-anode 7-segment display.
// A coherent digit/blank/dp snapshot is captured once per frame; brightness is applied live.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 12500,
  parameter int unsigned AN_NUM   = 8,
  parameter int unsigned CATH_NUM = 7
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [4*AN_NUM-1:0]   num_i,
  input  logic [AN_NUM-1:0]     blank_i,
  input  logic [AN_NUM-1:0]     dp_i,
  input  logic [3:0]            bright_i,
  input  logic                  en_i,
  output logic [CATH_NUM-1:0]   cath_o,
  output logic                  dp_o,
  output logic [AN_NUM-1:0]     an_o,
  output logic                  frame_o
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W  = $clog2(AN_NUM);
  localparam int unsigned THR_W  = CNT_W + 1;
  localparam int unsigned SLOT16 = SCAN_DIV / 16;

  logic [CNT_W-1:0]    cnt;
  logic [DIG_W-1:0]    dig;
  logic                run;
  logic [4*AN_NUM-1:0] num_s;
  logic [AN_NUM-1:0]   blank_s;
  logic [AN_NUM-1:0]   dp_s;

  logic                slot_end_c;
  logic                wrap_c;
  logic                first_c;
  logic                capture_c;
  logic [4*AN_NUM-1:0] num_eff_c;
  logic [AN_NUM-1:0]   blank_eff_c;
  logic [AN_NUM-1:0]   dp_eff_c;
  logic [3:0]          nib_c;
  logic [CATH_NUM-1:0] seg_c;
  logic [THR_W-1:0]    thr_c;
  logic                lit_c;

  // Frame wrap captures for the next frame; the first enabled cycle uses the inputs directly
  // so digit 0 already shows fresh data in the cycle after (re)enable.
  always_comb begin
    slot_end_c  = (cnt == CNT_W'(SCAN_DIV - 1));
    wrap_c      = en_i && slot_end_c && (dig == DIG_W'(AN_NUM - 1));
    first_c     = en_i && !run;
    capture_c   = first_c || wrap_c;
    num_eff_c   = first_c ? num_i   : num_s;
    blank_eff_c = first_c ? blank_i : blank_s;
    dp_eff_c    = first_c ? dp_i    : dp_s;
    nib_c       = num_eff_c[{dig, 2'b00} +: 4];
    thr_c       = THR_W'(bright_i) * THR_W'(SLOT16);
    lit_c       = en_i && !blank_eff_c[dig] && ({1'b0, cnt} < thr_c);
  end

  // Hex to active-high segments, bit6 = a ... bit0 = g
  always_comb begin
    seg_c = CATH_NUM'(7'h00);
    case (nib_c)
      4'h0: seg_c = CATH_NUM'(7'h7E);
      4'h1: seg_c = CATH_NUM'(7'h30);
      4'h2: seg_c = CATH_NUM'(7'h6D);
      4'h3: seg_c = CATH_NUM'(7'h79);
      4'h4: seg_c = CATH_NUM'(7'h33);
      4'h5: seg_c = CATH_NUM'(7'h5B);
      4'h6: seg_c = CATH_NUM'(7'h5F);
      4'h7: seg_c = CATH_NUM'(7'h70);
      4'h8: seg_c = CATH_NUM'(7'h7F);
      4'h9: seg_c = CATH_NUM'(7'h7B);
      4'hA: seg_c = CATH_NUM'(7'h77);
      4'hB: seg_c = CATH_NUM'(7'h1F);
      4'hC: seg_c = CATH_NUM'(7'h4E);
      4'hD: seg_c = CATH_NUM'(7'h3D);
      4'hE: seg_c = CATH_NUM'(7'h4F);
      default: seg_c = CATH_NUM'(7'h47);
    endcase
  end

  // Scan counters and shadow snapshot
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      dig     <= '0;
      run     <= 1'b0;
      num_s   <= '0;
      blank_s <= '1;
      dp_s    <= '0;
    end else begin
      run <= en_i;
      if (!en_i) begin
        cnt <= '0;
        dig <= '0;
      end else if (slot_end_c) begin
        cnt <= '0;
        dig <= (dig == DIG_W'(AN_NUM - 1)) ? '0 : dig + DIG_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (capture_c) begin
        num_s   <= num_i;
        blank_s <= blank_i;
        dp_s    <= dp_i;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      an_o    <= '1;
      cath_o  <= '1;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      an_o    <= lit_c ? ~(AN_NUM'(1) << dig) : '1;
      cath_o  <= en_i ? ~seg_c : '1;
      dp_o    <= en_i ? ~dp_eff_c[dig] : 1'b1;
      frame_o <= wrap_c;
    end
  end

endmodule
